out_unit: RTL and testbench

Output unit for the MIX machine: the transmit-side counterpart of the UART card-reader input unit. On an OUT command it fetches a 16-word block from memory through the CPU word handshake, converts each 6-bit MIX character to ASCII, and sends 80 characters plus CR LF over a built-in 8N1 UART transmitter. It sits beside the input unit on the CPU's I/O bus and uses the same start/stop/request/address conventions.

---
 rtl/out_unit.sv | 228 ++++++++++++++++++++++
 tb/tb_out_unit.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/out_unit.sv
// MIX output unit: fetches a 16-word block over the CPU word handshake and
// prints it as 80 ASCII characters plus CR LF on a built-in 8N1 UART line.
module out_unit #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] addressin,
    output logic [11:0] addressout,
    output logic        request,
    input  logic        load,
    input  logic [29:0] in,
    output logic        stop,
    output logic        busy,
    output logic        tx
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND,
        CR,
        LF,
        DONE
    } state_t;

    state_t             state;
    state_t             next_state;

    logic [29:0]        word_sr;
    logic [2:0]         char_cnt;
    logic [3:0]         word_cnt;
    logic               queued;
    logic [11:0]        address_next;

    logic               tx_active;
    logic [3:0]         bit_cnt;
    logic [BAUD_W-1:0]  baud_cnt;
    logic [8:0]         frame_sr;
    logic               bit_end;
    logic               last_tick;
    logic               uart_ready;

    logic               char_go;
    logic [7:0]         tx_char;
    logic               block_end;

    function automatic logic [7:0] mix_to_ascii(input logic [5:0] code);
        logic [7:0] c;
        c = {2'b00, code};
        if (code == 6'd0)                    return 8'h20;
        if (code <= 6'd9)                    return c + 8'h40;
        if (code >= 6'd11 && code <= 6'd19)  return c + 8'h3F;
        if (code >= 6'd22 && code <= 6'd29)  return c + 8'h3D;
        if (code >= 6'd30 && code <= 6'd39)  return c + 8'h12;
        case (code)
            6'd40:   return 8'h2E;
            6'd41:   return 8'h2C;
            6'd42:   return 8'h28;
            6'd43:   return 8'h29;
            6'd44:   return 8'h2B;
            6'd45:   return 8'h2D;
            6'd46:   return 8'h2A;
            6'd47:   return 8'h2F;
            6'd48:   return 8'h3D;
            6'd49:   return 8'h24;
            6'd50:   return 8'h3C;
            6'd51:   return 8'h3E;
            6'd52:   return 8'h40;
            6'd53:   return 8'h3B;
            6'd54:   return 8'h3A;
            6'd55:   return 8'h27;
            default: return 8'h3F;
        endcase
    endfunction

    // A frame may be followed by the next one in the very cycle its stop bit ends.
    assign bit_end    = tx_active && (baud_cnt == BAUD_LAST);
    assign last_tick  = bit_end && (bit_cnt == 4'd9);
    assign uart_ready = !tx_active || last_tick;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (start) next_state = FETCH;
            FETCH: if (load && request) next_state = SEND;
            SEND: begin
                if (char_cnt == 3'd5) begin
                    if (word_cnt == 4'd15)  next_state = CR;
                    else if (last_tick)     next_state = FETCH;
                end
            end
            CR:    if (uart_ready) next_state = LF;
            LF:    if (uart_ready) next_state = DONE;
            DONE:  if (last_tick) next_state = (queued || start) ? FETCH : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        char_go   = 1'b0;
        tx_char   = 8'h00;
        block_end = 1'b0;
        case (state)
            SEND: begin
                tx_char = mix_to_ascii(word_sr[29:24]);
                char_go = (char_cnt < 3'd5) && uart_ready;
            end
            CR: begin
                tx_char = 8'd13;
                char_go = uart_ready;
            end
            LF: begin
                tx_char = 8'd10;
                char_go = uart_ready;
            end
            DONE:    block_end = last_tick;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addressout   <= '0;
            address_next <= '0;
            request      <= 1'b0;
            stop         <= 1'b0;
            busy         <= 1'b0;
            queued       <= 1'b0;
            word_sr      <= '0;
            char_cnt     <= '0;
            word_cnt     <= '0;
        end else begin
            stop    <= 1'b0;
            // Raised on the edge that enters FETCH from SEND so a zero-latency
            // CPU costs only two idle cycles between words.
            request <= ((state == FETCH) && !(load && request)) ||
                       ((state == SEND) && (next_state == FETCH));

            if (state == IDLE) begin
                if (start) begin
                    addressout <= addressin;
                    busy       <= 1'b1;
                    stop       <= 1'b1;
                    word_cnt   <= '0;
                end
            end else if (block_end) begin
                queued <= 1'b0;
                if (queued) begin
                    addressout <= address_next;
                    stop       <= 1'b1;
                    word_cnt   <= '0;
                end else if (start) begin
                    addressout <= addressin;
                    stop       <= 1'b1;
                    word_cnt   <= '0;
                end else begin
                    busy <= 1'b0;
                end
            end else if (start && !queued) begin
                address_next <= addressin;
                queued       <= 1'b1;
            end

            if ((state == FETCH) && load && request) begin
                word_sr    <= in;
                addressout <= addressout + 12'd1;
                char_cnt   <= '0;
            end

            if ((state == SEND) && char_go) begin
                word_sr  <= {word_sr[23:0], 6'd0};
                char_cnt <= char_cnt + 3'd1;
            end

            if ((state == SEND) && (next_state == FETCH)) begin
                word_cnt <= word_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx        <= 1'b1;
            tx_active <= 1'b0;
            bit_cnt   <= '0;
            baud_cnt  <= '0;
            frame_sr  <= '1;
        end else if (char_go) begin
            tx        <= 1'b0;
            tx_active <= 1'b1;
            frame_sr  <= {1'b1, tx_char};
            bit_cnt   <= '0;
            baud_cnt  <= '0;
        end else if (tx_active) begin
            if (bit_end) begin
                baud_cnt <= '0;
                if (bit_cnt == 4'd9) begin
                    tx_active <= 1'b0;
                    tx        <= 1'b1;
                end else begin
                    bit_cnt  <= bit_cnt + 4'd1;
                    tx       <= frame_sr[0];
                    frame_sr <= {1'b1, frame_sr[8:1]};
                end
            end else begin
                baud_cnt <= baud_cnt + BAUD_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_out_unit.sv
// Directed bench for out_unit: block table plus queued-block and mid-frame
// reset sequences, with a UART receiver and a CPU word responder.
module tb_out_unit;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] addressin;
    logic [11:0] addressout;
    logic        request;
    logic        load;
    logic [29:0] in;
    logic        stop;
    logic        busy;
    logic        tx;

    out_unit #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .addressin  (addressin),
        .addressout (addressout),
        .request    (request),
        .load       (load),
        .in         (in),
        .stop       (stop),
        .busy       (busy),
        .tx         (tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] addr;
        int          lat;
        int          pat;
        logic [39:0] first5;
        int          exp_busy;
    } blk_t;

    string map_str = " ABCDEFGHI?JKLMNOPQR??STUVWXYZ0123456789.,()+-*/=$<>@;:'????????";

    int          errors = 0;
    int          checks = 0;
    logic [29:0] mem [0:4095];
    int          cpu_lat = 0;
    logic [7:0]  rx_q [$];
    logic [11:0] addr_q [$];
    int          frame_err = 0;
    int          stop_cnt = 0;
    int          dbl_stop = 0;
    int          wait_total = 0;
    int          slow_tx_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [29:0] word_for(input int pat, input logic [11:0] a, input int idx);
        logic [29:0] w;
        w = {6'd1, 6'd2, 6'd3, 6'd30, 6'd0};
        if (pat == 1 && idx < 13) begin
            for (int k = 0; k < 5; k++) w[29-6*k -: 6] = 6'((5 * idx + k) % 64);
        end else if (pat == 2) begin
            w = {a[5:0], a[11:6], 6'd45, 6'd40, 6'd0};
        end
        return w;
    endfunction

    function automatic logic [31:0] exp_byte(input logic [11:0] base, input int i);
        logic [11:0] a;
        logic [29:0] w;
        logic [5:0]  code;
        if (i == 80) return 32'd13;
        if (i == 81) return 32'd10;
        a    = base + 12'(i / 5);
        w    = mem[a];
        code = w[29-6*(i%5) -: 6];
        return {24'd0, map_str[code]};
    endfunction

    function automatic logic [31:0] get_rx(input int idx);
        if (idx < rx_q.size()) return {24'd0, rx_q[idx]};
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] get_addr(input int idx);
        if (idx < addr_q.size()) return {20'd0, addr_q[idx]};
        return 32'hFFFF_FFFF;
    endfunction

    // UART receiver: samples each bit at its middle.
    initial begin
        logic [7:0] rx_byte;
        forever begin
            @(negedge tx);
            #25;
            if (tx !== 1'b0) begin
                frame_err++;
            end else begin
                for (int b = 0; b < 8; b++) begin
                    #40;
                    rx_byte[b] = tx;
                end
                #40;
                if (tx !== 1'b1) frame_err++;
                rx_q.push_back(rx_byte);
            end
        end
    end

    // CPU side: answers a request after cpu_lat cycles with a one-cycle load.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        load = 1'b0;
        in   = '0;
        forever begin
            @(negedge clk);
            if (load) begin
                load = 1'b0;
            end else if (reset === 1'b1 && request === 1'b1) begin
                if (wait_cnt >= cpu_lat) begin
                    load     = 1'b1;
                    in       = mem[addressout];
                    addr_q.push_back(addressout);
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                    wait_total++;
                    if (tx !== 1'b1) slow_tx_err++;
                end
            end
        end
    end

    initial begin
        logic prev_stop;
        prev_stop = 1'b0;
        forever begin
            @(negedge clk);
            if (stop === 1'b1) begin
                stop_cnt++;
                if (prev_stop) dbl_stop++;
            end
            prev_stop = stop;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic pulse_start(input logic [11:0] a);
        @(negedge clk);
        addressin = a;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        addressin = '0;
    endtask

    task automatic run_block(input blk_t b);
        int          rx_base, addr_base, stop_base, ferr_base, wait_base, stx_base;
        int          k, busy_cyc, first_tx;
        logic [11:0] a;
        for (int i = 0; i < 16; i++) begin
            a      = b.addr + 12'(i);
            mem[a] = word_for(b.pat, a, i);
        end
        cpu_lat   = b.lat;
        rx_base   = rx_q.size();
        addr_base = addr_q.size();
        stop_base = stop_cnt;
        ferr_base = frame_err;
        wait_base = wait_total;
        stx_base  = slow_tx_err;

        pulse_start(b.addr);
        check("busy_after_start", busy, 1);
        check("stop_after_start", stop, 1);
        busy_cyc = (busy === 1'b1) ? 1 : 0;
        @(negedge clk);
        check("request_two_after_start", request, 1);
        check("stop_single_cycle", stop, 0);
        if (busy === 1'b1) busy_cyc++;
        k        = 2;
        first_tx = -1;
        while (busy === 1'b1 && k < 20000) begin
            @(negedge clk);
            k++;
            if (k == 3 + b.lat) begin
                check("request_low_after_load", request, 0);
                check("addr_incr_after_load", addressout, b.addr + 12'd1);
            end
            if (first_tx < 0 && tx === 1'b0) first_tx = k;
            if (busy === 1'b1) busy_cyc++;
        end
        check("busy_falls", busy, 0);
        check("busy_cycles", busy_cyc, b.exp_busy);
        check("first_start_bit_cycle", first_tx, 4 + b.lat);
        check("rx_count", rx_q.size() - rx_base, 82);
        for (int i = 0; i < 5; i++)
            check($sformatf("first5[%0d]", i), get_rx(rx_base + i), {24'd0, b.first5[39-8*i -: 8]});
        for (int i = 0; i < 82; i++)
            check($sformatf("byte[%0d]", i), get_rx(rx_base + i), exp_byte(b.addr, i));
        check("addr_count", addr_q.size() - addr_base, 16);
        for (int i = 0; i < 16; i++)
            check($sformatf("addr[%0d]", i), get_addr(addr_base + i), {20'd0, b.addr + 12'(i)});
        check("stop_pulses", stop_cnt - stop_base, 1);
        check("frame_errors", frame_err - ferr_base, 0);
        check("cpu_wait_cycles", wait_total - wait_base, 16 * b.lat);
        check("tx_low_while_waiting", slow_tx_err - stx_base, 0);
    endtask

    initial begin
        blk_t tbl [4];
        int   rx_base, rx_base2, addr_base, addr_base2, stop_base;
        int   k, busy_drop, cnt_a, cnt_b;

        tbl[0] = '{addr: 12'd100,  lat: 0,  pat: 0, first5: "ABC0 ", exp_busy: 3313};
        tbl[1] = '{addr: 12'd300,  lat: 0,  pat: 1, first5: " ABCD", exp_busy: 3313};
        tbl[2] = '{addr: 12'd400,  lat: 50, pat: 2, first5: "OF-. ", exp_busy: 4113};
        tbl[3] = '{addr: 12'd4090, lat: 0,  pat: 2, first5: "??-. ", exp_busy: 3313};

        reset     = 1'b0;
        start     = 1'b0;
        addressin = '0;
        repeat (3) @(negedge clk);
        check("reset_tx", tx, 1);
        check("reset_busy", busy, 0);
        check("reset_stop", stop, 0);
        check("reset_request", request, 0);
        check("reset_addressout", addressout, 0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        for (int t = 0; t < 4; t++) begin
            run_block(tbl[t]);
            repeat (20) @(negedge clk);
        end

        // Second start while busy is queued; a third one is dropped.
        for (int i = 0; i < 16; i++) begin
            mem[12'd100 + 12'(i)] = word_for(0, 12'd100 + 12'(i), i);
            mem[12'd200 + 12'(i)] = word_for(2, 12'd200 + 12'(i), i);
        end
        cpu_lat   = 0;
        rx_base   = rx_q.size();
        addr_base = addr_q.size();
        stop_base = stop_cnt;
        pulse_start(12'd100);
        repeat (600) @(negedge clk);
        pulse_start(12'd200);
        check("queue_no_stop", stop, 0);
        check("queue_busy", busy, 1);
        repeat (50) @(negedge clk);
        pulse_start(12'd300);
        k         = 0;
        busy_drop = 0;
        while (stop !== 1'b1 && k < 10000) begin
            @(negedge clk);
            k++;
            if (busy !== 1'b1) busy_drop++;
        end
        check("queue_stop_seen", stop, 1);
        check("queue_busy_at_switch", busy, 1);
        check("queue_addr_at_switch", addressout, 200);
        check("blk1_rx_count", rx_q.size() - rx_base, 82);
        check("blk1_addr_count", addr_q.size() - addr_base, 16);
        for (int i = 0; i < 82; i++)
            check($sformatf("blk1_byte[%0d]", i), get_rx(rx_base + i), exp_byte(12'd100, i));
        rx_base2   = rx_q.size();
        addr_base2 = addr_q.size();
        @(negedge clk);
        check("stop_count_at_switch", stop_cnt - stop_base, 2);
        k = 0;
        while (busy === 1'b1 && k < 10000) begin
            @(negedge clk);
            k++;
        end
        check("queue_busy_never_dropped", busy_drop, 0);
        check("blk2_busy_falls", busy, 0);
        check("blk2_rx_count", rx_q.size() - rx_base2, 82);
        for (int i = 0; i < 82; i++)
            check($sformatf("blk2_byte[%0d]", i), get_rx(rx_base2 + i), exp_byte(12'd200, i));
        for (int i = 0; i < 16; i++)
            check($sformatf("blk2_addr[%0d]", i), get_addr(addr_base2 + i), 200 + i);
        cnt_a = 0;
        repeat (200) begin
            @(negedge clk);
            if (busy !== 1'b0) cnt_a++;
        end
        check("third_start_ignored", cnt_a, 0);
        check("queue_stop_total", stop_cnt - stop_base, 2);
        check("no_double_stop", dbl_stop, 0);

        // Reset in the middle of a frame.
        for (int i = 0; i < 16; i++) mem[12'd500 + 12'(i)] = word_for(0, 12'd500 + 12'(i), i);
        pulse_start(12'd500);
        k = 0;
        while (tx !== 1'b0 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("midframe_tx_low", tx, 0);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        check("async_reset_tx", tx, 1);
        check("async_reset_busy", busy, 0);
        check("async_reset_request", request, 0);
        check("async_reset_addressout", addressout, 0);
        check("async_reset_stop", stop, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        cnt_a = 0;
        cnt_b = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx !== 1'b1) cnt_a++;
            if (busy !== 1'b0 || request !== 1'b0) cnt_b++;
        end
        check("post_reset_tx_idle", cnt_a, 0);
        check("post_reset_no_activity", cnt_b, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
